// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store memory master.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (word-crossing accesses split in two).
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    RESP = 3'd5
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size in bytes (1/2/4); funct3[1:0]==11 is caught by f3_legal.
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   f3_size = 3'd1;
      2'b01:   f3_size = 3'd2;
      default: f3_size = 3'd4;
    endcase
  endfunction

  // Loads accept B/H/W/BU/HU; stores only B/H/W.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  // Access spills into the next word when offset + size exceeds one word.
  function automatic logic is_split(input logic [1:0] off, input logic [2:0] size);
    is_split = ({1'b0, off} + size) > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: load extract/extend from a {w1,w0} window and
// store merge of new bytes into one or two old words. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  f3_i,
  input  logic [1:0]  off_i,
  input  logic [63:0] win_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] old0_i,
  input  logic [31:0] old1_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] new0_o,
  output logic [31:0] new1_o
);

  logic [5:0]  sh;
  logic [31:0] shifted;
  logic [3:0]  smask;
  logic [7:0]  bmask;
  logic [63:0] sdata;
  logic [63:0] old;
  logic [63:0] merged;

  assign sh      = {off_i, 3'b000};
  assign shifted = 32'(win_i >> sh);

  // Sign- or zero-extend the addressed bytes down at lane 0.
  always_comb begin
    ld_data_o = '0;
    case (f3_i)
      F3_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    ld_data_o = shifted;
      F3_BU:   ld_data_o = {24'b0, shifted[7:0]};
      F3_HU:   ld_data_o = {16'b0, shifted[15:0]};
      default: ld_data_o = '0;
    endcase
  end

  // Byte-enable pattern for the access size before shifting to the offset.
  always_comb begin
    case (f3_i[1:0])
      2'b00:   smask = 4'b0001;
      2'b01:   smask = 4'b0011;
      default: smask = 4'b1111;
    endcase
  end

  assign bmask = {4'b0, smask} << off_i;
  assign sdata = {32'b0, wdata_i} << sh;
  assign old   = {old1_i, old0_i};

  for (genvar l = 0; l < 8; l++) begin : g_lane
    assign merged[l*8 +: 8] = bmask[l] ? sdata[l*8 +: 8] : old[l*8 +: 8];
  end

  assign new0_o = merged[31:0];
  assign new1_o = merged[63:32];

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator to a single-port word SRAM without byte enables.
// Sub-word stores are read-modify-write; loads are extended.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN -- when defined, accesses
// crossing a word boundary are split into two word accesses; otherwise
// they are rejected with resp_err and no SRAM traffic.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = DM_ADDRESS + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rd
);

  lsu_state_e state_q, state_d;

  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic                  split_q, split_d;
  logic                  err_q, err_d;
  logic [DM_ADDRESS-1:0] wa_q, wa_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     d0_q, d0_d;
  logic [DATA_W-1:0]     d1_q, d1_d;

  logic [2:0]            rq_size;
  logic [1:0]            rq_off;
  logic [DM_ADDRESS-1:0] rq_wa;
  logic                  rq_split;
  logic                  rq_err;
  logic                  rq_sw_aligned;

  logic [DATA_W-1:0]     ld_data, new0, new1, old0;

  // Decode of the incoming request, used only for the first access in IDLE.
  assign rq_off        = req_addr[1:0];
  assign rq_wa         = req_addr[ADDR_W-1:2];
  assign rq_size       = f3_size(req_funct3);
  assign rq_split      = is_split(rq_off, rq_size);
  assign rq_sw_aligned = req_we && (req_funct3 == F3_W) && (rq_off == 2'b00);
`ifdef LSU_MISALIGN_SPLIT_EN
  assign rq_err = !f3_legal(req_funct3, req_we);
  logic [DM_ADDRESS-1:0] wa1;
  // Second word wraps around the top of the SRAM.
  assign wa1 = wa_q + {{(DM_ADDRESS-1){1'b0}}, 1'b1};
`else
  assign rq_err = !f3_legal(req_funct3, req_we) || rq_split;
`endif

  // Non-split RMW merges straight from the read data; split RMW uses the
  // captured low word because mem_rd then carries the high word.
  assign old0 = split_q ? d0_q : mem_rd;

  lsu_lane_align u_align (
    .f3_i      (f3_q),
    .off_i     (off_q),
    .win_i     ({d1_q, d0_q}),
    .wdata_i   (wdata_q),
    .old0_i    (old0),
    .old1_i    (mem_rd),
    .ld_data_o (ld_data),
    .new0_o    (new0),
    .new1_o    (new1)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? ld_data : '0;

  // Next-state, request capture and SRAM access sequencing.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    split_d = split_q;
    err_d   = err_q;
    wa_d    = wa_q;
    wdata_d = wdata_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    mem_ce  = 1'b0;
    mem_we  = 1'b0;
    mem_a   = '0;
    mem_wd  = '0;
    case (state_q)
      IDLE: begin
        // rst_n gate keeps the SRAM quiet while reset is held.
        if (req_valid && rst_n) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          off_d   = rq_off;
          split_d = rq_split;
          err_d   = rq_err;
          wa_d    = rq_wa;
          wdata_d = req_wdata;
          if (rq_err) begin
            state_d = RESP;
          end else if (rq_sw_aligned) begin
            mem_ce  = 1'b1;
            mem_we  = 1'b1;
            mem_a   = rq_wa;
            mem_wd  = req_wdata;
            state_d = RESP;
          end else begin
            mem_ce  = 1'b1;
            mem_a   = rq_wa;
            state_d = (req_we && !rq_split) ? WR_A : RD_A;
          end
        end
      end
      RD_A: begin
        d0_d    = mem_rd;
        state_d = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (split_q) begin
          mem_ce  = 1'b1;
          mem_a   = wa1;
          state_d = we_q ? WR_A : RD_B;
        end
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      RD_B: begin
        d1_d    = mem_rd;
        state_d = RESP;
      end
`endif
      WR_A: begin
        mem_ce  = 1'b1;
        mem_we  = 1'b1;
        mem_a   = wa_q;
        mem_wd  = new0;
        d1_d    = new1;
        state_d = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (split_q) state_d = WR_B;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      WR_B: begin
        mem_ce  = 1'b1;
        mem_we  = 1'b1;
        mem_a   = wa1;
        mem_wd  = d1_q;
        state_d = RESP;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request/data registers; reset abandons any sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      wa_q    <= '0;
      wdata_q <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      split_q <= split_d;
      err_q   <= err_d;
      wa_q    <= wa_d;
      wdata_q <= wdata_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-level reference memory model, per-cycle
// response/handshake compare, directed vectors with literal expectations.
module tb_lsu_mem_master;

  localparam int DM = 9;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic [DM-1:0] mem_a;
  logic          mem_ce, mem_we;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd_q;

  always #5 clk = ~clk;

  lsu_mem_master #(.DM_ADDRESS(DM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_a(mem_a), .mem_ce(mem_ce), .mem_we(mem_we), .mem_wd(mem_wd),
    .mem_rd(mem_rd_q)
  );

  // SRAM behavioural model plus a bench-side preload port.
  logic [31:0] sram [512];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_a;
  logic [31:0] pl_d;
  always @(posedge clk) begin
    if (pl_en) sram[pl_a] <= pl_d;
    else if (mem_ce) begin
      if (mem_we) sram[mem_a] <= mem_wd;
      else        mem_rd_q <= sram[mem_a];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  ref_b [2048];
  int          checks = 0, errors = 0;
  int          req_cnt = 0, rsp_cnt = 0;
  int          acc_cyc, exp_cyc, exp_nacc, n_acc;
  logic [31:0] exp_rdata, last_rdata;
  logic        exp_err, last_err;
  bit          quiet = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  task automatic set_ref(input int w, input logic [31:0] v);
    for (int b = 0; b < 4; b++) ref_b[4*w+b] = v[8*b +: 8];
  endtask

  task automatic preload(input int w, input logic [31:0] v);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_a = w[8:0]; pl_d = v; set_ref(w, v);
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Reference behaviour from the byte view of memory: latency, access count,
  // response data/error; stores update the byte memory.
  task automatic model(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                       input logic [31:0] wd, output int lat, output int nacc,
                       output logic [31:0] rd, output logic er);
    int s, o;
    bit legal, split, split_en;
    logic [31:0] v;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_en = 1'b1;
`else
    split_en = 1'b0;
`endif
    s = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = (f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    o = int'(addr[1:0]);
    split = (o + s) > 4;
    rd = '0; er = 1'b0; lat = 1; nacc = 0;
    if (!legal || (split && !split_en)) begin
      er = 1'b1;
    end else if (!we) begin
      v = '0;
      for (int i = 0; i < s; i++) v[8*i +: 8] = ref_b[(int'(addr) + i) & 2047];
      rd = v;
      if (f3 == 3'd0 && v >= 32'd128)   rd = v - 32'd256;
      if (f3 == 3'd1 && v >= 32'd32768) rd = v - 32'd65536;
      lat  = split ? 3 : 2;
      nacc = split ? 2 : 1;
    end else begin
      for (int i = 0; i < s; i++) ref_b[(int'(addr) + i) & 2047] = wd[8*i +: 8];
      if (s == 4 && o == 0) begin lat = 1; nacc = 1; end
      else if (split)       begin lat = 4; nacc = 4; end
      else                  begin lat = 2; nacc = 2; end
    end
  endtask

  // Per-cycle compare of handshake, SRAM activity and response.
  task automatic compare_loop();
    bit act;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        act = (req_cnt != rsp_cnt);
        if (act) n_acc = (cyc == acc_cyc) ? int'(mem_ce) : n_acc + int'(mem_ce);
        if (!quiet) begin
          chkb("req_ready", req_ready, !(act && cyc != acc_cyc));
          if (!act) chkb("idle_mem_ce", mem_ce, 1'b0);
        end
        chkb("resp_valid", resp_valid, act && cyc == exp_cyc);
        if (act && cyc == exp_cyc) begin
          chk("resp_rdata", resp_rdata, exp_rdata);
          chkb("resp_err", resp_err, exp_err);
          chk("sram_accesses", n_acc, exp_nacc);
          last_rdata = resp_rdata;
          last_err   = resp_err;
          rsp_cnt++;
        end
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                        input logic [31:0] wd);
    int lat, nacc, w0, w1;
    logic [31:0] rd;
    logic er;
    @(posedge clk); #1;
    model(we, f3, addr, wd, lat, nacc, rd, er);
    acc_cyc = cyc; exp_cyc = cyc + lat; exp_nacc = nacc;
    exp_rdata = rd; exp_err = er;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    req_cnt++;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must have no effect.
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'($urandom);
    req_addr = AW'($urandom); req_wdata = $urandom;
    for (int i = 0; i < 12 && rsp_cnt != req_cnt; i++) begin
      @(posedge clk); #1;
    end
    if (rsp_cnt != req_cnt) begin
      chkb("resp_timeout", 1'b0, 1'b1);
      req_cnt = rsp_cnt;
      rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    end
    w0 = int'(addr[AW-1:2]);
    w1 = (w0 + 1) % 512;
    chk("mem_word0", sram[w0], ref_word(w0));
    chk("mem_word1", sram[w1], ref_word(w1));
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    fork compare_loop(); join_none

    // Fill SRAM and reference with a known pattern while in reset.
    @(posedge clk); #1;
    pl_en = 1'b1;
    for (int w = 0; w < 512; w++) begin
      pl_a = w[8:0]; pl_d = 32'h9E3779B9 * 32'(w + 1); set_ref(w, pl_d);
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    chkb("rst_req_ready", req_ready, 1'b1);
    chkb("rst_resp_valid", resp_valid, 1'b0);
    chkb("rst_resp_err", resp_err, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chkb("rst_mem_ce", mem_ce, 1'b0);
    chkb("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_a", 32'(mem_a), 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Byte loads with sign / zero extension.
    preload(5, 32'h8899AABB);
    do_req(1'b0, 3'b000, 11'h015, '0);
    chk("lit_lb", last_rdata, 32'hFFFFFFAA);
    do_req(1'b0, 3'b100, 11'h015, '0);
    chk("lit_lbu", last_rdata, 32'h000000AA);
    do_req(1'b0, 3'b001, 11'h015, '0);
    chk("lit_lh_o1", last_rdata, 32'hFFFF99AA);

    // Aligned word store then halfword load.
    do_req(1'b1, 3'b010, 11'h020, 32'h12345678);
    chk("lit_sw_word8", sram[8], 32'h12345678);
    do_req(1'b0, 3'b001, 11'h022, '0);
    chk("lit_lh", last_rdata, 32'h00001234);

    // Byte store as read-modify-write.
    preload(8, 32'hFFFFFFFF);
    do_req(1'b1, 3'b000, 11'h021, 32'h0000005A);
    chk("lit_sb_word8", sram[8], 32'hFFFF5AFF);

    // Illegal funct3.
    do_req(1'b0, 3'b011, 11'h010, '0);
    chkb("lit_f3_011_err", last_err, 1'b1);
    do_req(1'b1, 3'b100, 11'h010, 32'h1);
    do_req(1'b0, 3'b111, 11'h010, '0);

    // Word-crossing accesses, including wrap from word 511 to word 0.
    preload(3, 32'h44332211);
    preload(4, 32'h88776655);
    preload(511, 32'h01020304);
    preload(0, 32'h05060708);
    do_req(1'b0, 3'b010, 11'h00E, '0);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("lit_lw_split", last_rdata, 32'h66554433);
`else
    chkb("lit_lw_split_err", last_err, 1'b1);
`endif
    do_req(1'b1, 3'b010, 11'h7FF, 32'hA1B2C3D4);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("lit_sw_wrap_hi", 32'(sram[511][31:24]), 32'hD4);
    chk("lit_sw_wrap_lo", 32'(sram[0][23:0]), 32'hA1B2C3);
`else
    chkb("lit_sw_wrap_err", last_err, 1'b1);
`endif
    do_req(1'b1, 3'b001, 11'h013, 32'h0000BEEF);
    do_req(1'b0, 3'b101, 11'h013, '0);

    // Every funct3 at every offset, loads then stores.
    for (int f = 0; f < 8; f++)
      for (int o = 0; o < 4; o++)
        do_req(1'b0, 3'(f), 11'(32'h014 + o), '0);
    for (int f = 0; f < 8; f++)
      for (int o = 0; o < 4; o++)
        do_req(1'b1, 3'(f), 11'(32'h030 + o), $urandom);

    // Reset while an RMW is about to write: the write must not happen.
    preload(9, 32'h11223344);
    quiet = 1'b1;
    @(posedge clk); #1;
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 11'h025; req_wdata = 32'h000000EE;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chkb("wra_mem_we", mem_we, 1'b1);
    chk("wra_mem_wd", mem_wd, 32'h1122EE44);
    rst_n = 1'b0;
    #1;
    chkb("rst2_req_ready", req_ready, 1'b1);
    chkb("rst2_resp_valid", resp_valid, 1'b0);
    chkb("rst2_mem_ce", mem_ce, 1'b0);
    chkb("rst2_mem_we", mem_we, 1'b0);
    chk("rst2_mem_a", 32'(mem_a), 32'h0);
    chk("rst2_mem_wd", mem_wd, 32'h0);
    chk("rst2_resp_rdata", resp_rdata, 32'h0);
    @(posedge clk); #1;
    chk("rst2_no_write", sram[9], 32'h11223344);
    rst_n = 1'b1;
    quiet = 1'b0;
    do_req(1'b0, 3'b010, 11'h024, '0);
    chk("lit_lw_after_rst", last_rdata, 32'h11223344);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
Initiator side of the load/store data-memory interface. Takes one load or store request at a time from the execute/memory stage and issues single-port word accesses to a 512x32 synchronous SRAM that has no byte enables. Sub-word stores are done as read-modify-write, and loads are sign- or zero-extended. With the optional feature, word-crossing misaligned accesses are split into two word accesses. Sits between the pipeline memory stage and the SRAM wrapper.

Parameters:
DM_ADDRESS, 9, word-address width of the SRAM (2**DM_ADDRESS words)
DATA_W, 32, data width; fixed at 32
ADDR_W, DM_ADDRESS+2, byte-address width of requests

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block idle, request accepted when req_valid&&req_ready
req_we  in  1  1=store, 0=load
req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, low bytes used for SB/SH
resp_valid  out  1  one-cycle pulse: load data valid / store done
resp_rdata  out  DATA_W  extended load result, 0 for stores
resp_err  out  1  illegal funct3 or unsupported misalign, valid with resp_valid
mem_a  out  DM_ADDRESS  SRAM word address
mem_ce  out  1  SRAM access this cycle
mem_we  out  1  1=write (wrapper inverts to WEB)
mem_wd  out  DATA_W  SRAM write word
mem_rd  in  DATA_W  SRAM read word, valid the cycle after a read access

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_ce=0, mem_we=0, mem_a=0, mem_wd=0. An in-flight sequence is abandoned. A partial RMW is not completed.
- States: IDLE, RD_A, RD_B, WR_A, WR_B, RESP. req_ready=1 only in IDLE.
- In IDLE the first SRAM access on acceptance is decoded combinationally from req_*. Later accesses use registered request fields.
- Word index w0=addr[ADDR_W-1:2], offset o=addr[1:0], size s=1/2/4. Access is split when o+s>4. w1=w0+1 wraps modulo 2**DM_ADDRESS (511->0).
- Illegal funct3 (011, 11x; store with 1xx): no SRAM traffic; resp_valid=1, resp_err=1 at T+1.
- Aligned/non-split load accepted at T: read w0 at T; capture at T+1; resp_valid at T+2.
- Split load: read w0 at T, read w1 at T+1, resp at T+3. Bytes are taken little-endian from {w1,w0} starting at o.
- Load extension: B/H sign-extend from bit 7/15; BU/HU zero-extend.
- SW with o=0: write at T; resp at T+1; no read.
- Non-split SB/SH: read w0 at T; at T+1 write w0 with lanes o..o+s-1 replaced; resp at T+2.
- Split SH/SW: read w0 at T, read w1 at T+1, write merged w0 at T+2, write merged w1 at T+3, resp at T+4.
- Only one SRAM access per cycle. mem_ce=0 in every cycle without an access.
- resp_valid is a single cycle in RESP, then IDLE. There is no response backpressure. A new request can be accepted in the cycle after RESP.
- req_* is ignored while req_ready=0. A request is registered at acceptance, so later input changes have no effect.

Optional Feature:
LSU_MISALIGN_SPLIT_EN
- Defined: split accesses are performed as described above.
- Undefined: any access with o+s>4 gets no SRAM traffic and resp_valid=1, resp_err=1 at T+1. RD_B and WR_B are not built.
- Non-split misaligned accesses (e.g. LH at o=1) are legal in both builds.

Decomposition:
- Package lsu_pkg: state enum, funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), size decode function.
- Sub-module lsu_lane_align, combinational:
  - load extract/extend from a 64-bit {w1,w0} window;
  - store merge of new bytes into one or two old words.
- FSM and registers stay in lsu_mem_master.

Test Plan:
- Preload word 5 = 0x8899AABB. LB addr 0x15 -> resp_rdata 0xFFFFFFAA at T+2. LBU same address -> 0x000000AA.
- SW 0x12345678 @0x20 -> single write, word 8 = 0x12345678, resp at T+1. Then LH @0x22 -> 0x00001234.
- Preload word 8 = 0xFFFFFFFF. SB 0x5A @0x21 -> read then write, word 8 = 0xFFFF5AFF, resp at T+2.
- Split build: words 3=0x44332211, 4=0x88776655; LW @0x0E -> 0x66554433 at T+3. SW 0xA1B2C3D4 @0x7FF (word 511 -> 0 wrap): word 511 top byte = 0xD4, word 0 low 3 bytes = 0xA1B2C3, resp at T+4.
- Non-split build: LW @0x0E -> resp_err=1 at T+1, mem_ce never high. funct3=011 load -> resp_err=1.
- Assert rst_n low during WR_A of an RMW -> outputs at reset values immediately, req_ready=1. After release, a new LW completes normally.
